fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the combinational instruction ROM. It holds the program counter and drives the ROM word address.
- Captures the returned instruction word into the IF/ID pipeline register consumed by decode.
- Handles stall, flush and branch/jump redirect, including a redirect that arrives during a stall.
- Detects out-of-range and misaligned fetches and parks in a fault state.

---
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of a combinational instruction ROM.
// It holds the program counter, drives the ROM word address and captures the
// returned word into the IF/ID register. It also handles stall, flush and
// redirect, and a redirect that arrives while the stage is stalled.
// A misaligned redirect target or an out-of-range fetch parks the stage in FAULT.
// Only reset leaves FAULT.
// Optional build macro: BRANCH_DELAY_SLOT_EN. When it is defined, the sequential
// instruction fetched on a redirect edge is kept as a delay slot. When it is
// undefined, that instruction is squashed.

module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

`ifdef BRANCH_DELAY_SLOT_EN
  localparam logic DELAY_SLOT = 1'b1;
`else
  localparam logic DELAY_SLOT = 1'b0;
`endif

  localparam logic [31:0] ROM_LIMIT = 32'(ROM_WORDS);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic        pending;
  logic [31:0] pending_pc;

  logic [31:0] pc_plus4;
  logic        take_redirect;
  logic [31:0] target;
  logic        misaligned;
  logic        out_of_range;
  logic        capture_valid;

  assign rom_addr = {2'b00, pc_q[31:2]};
  assign pc_plus4 = pc_q + 32'd4;

  // Choose the redirect target and decide whether this edge faults or keeps its capture.
  // A live redirect takes priority over one remembered from a stall.
  always_comb begin
    take_redirect = redirect_valid | pending;
    target        = redirect_valid ? redirect_pc : pending_pc;
    misaligned    = take_redirect && (target[1:0] != 2'b00);
    out_of_range  = (rom_addr >= ROM_LIMIT);
    capture_valid = ~flush & (~take_redirect | DELAY_SLOT);
  end

  // Fetch state machine. It updates the PC, the pending redirect, the IF/ID register and the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc_q        <= RESET_PC;
      pending     <= 1'b0;
      pending_pc  <= 32'd0;
      if_id_instr <= 32'd0;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      case (state)
        RUN: begin
          if (stall) begin
            if (flush) begin
              if_id_valid <= 1'b0;
            end
            if (redirect_valid) begin
              pending    <= 1'b1;
              pending_pc <= redirect_pc;
            end
          end else if (out_of_range || misaligned) begin
            state       <= FAULT;
            fetch_fault <= 1'b1;
            if_id_valid <= 1'b0;
            pending     <= 1'b0;
          end else begin
            if_id_instr <= rom_rdata;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= capture_valid;
            if (capture_valid) begin
              fetch_count <= fetch_count + 32'd1;
            end
            pc_q    <= take_redirect ? target : pc_plus4;
            pending <= 1'b0;
          end
        end
        FAULT: begin
          if_id_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// It runs directed steps and then randomized traffic. Every result is checked against a
// behavioural model of the fetch stage, written from the stage's rules.
// The bench follows BRANCH_DELAY_SLOT_EN in the same way as the design.

module tb_fetch_unit;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  localparam int ROMN = 1024;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] rom_addr;
  logic [31:0] rom_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  logic [31:0] rom [0:ROMN-1];

  int checksTotal;
  int checksPassed;

  // Model state: the architectural view of the fetch stage.
  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic [31:0] mPc4;
  bit          mValid;
  bit          mFault;
  logic [31:0] mCount;
  bit          mPending;
  logic [31:0] mPendingPc;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .ROM_WORDS(ROMN)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .rom_addr      (rom_addr),
    .rom_rdata     (rom_rdata),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .fetch_fault   (fetch_fault),
    .fetch_count   (fetch_count)
  );

  // Combinational ROM. Reads beyond the ROM return a recognisable filler word.
  assign rom_rdata = (rom_addr < 32'(ROMN)) ? rom[rom_addr[9:0]] : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checksTotal++;
    assert (obs === exp) checksPassed++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance the model by one clock edge, using the inputs that are currently driven.
  task automatic modelEdge();
    bit          redirecting;
    logic [31:0] tgt;
    bit          keep;
    if (rst) begin
      mPc = 32'd0; mInstr = 32'd0; mPc4 = 32'd0; mValid = 0;
      mFault = 0; mCount = 32'd0; mPending = 0; mPendingPc = 32'd0;
    end else if (mFault) begin
      mValid = 0;
    end else if (stall) begin
      if (flush) mValid = 0;
      if (redirect_valid) begin
        mPending = 1;
        mPendingPc = redirect_pc;
      end
    end else begin
      redirecting = redirect_valid || mPending;
      tgt = redirect_valid ? redirect_pc : mPendingPc;
      if ((mPc / 4) >= ROMN || (redirecting && (tgt % 4) != 0)) begin
        mFault = 1;
        mValid = 0;
      end else begin
        mInstr = rom[mPc / 4];
        mPc4   = mPc + 4;
        keep   = !flush && (!redirecting || DS);
        mValid = keep;
        if (keep) mCount = mCount + 1;
        mPc = redirecting ? tgt : mPc + 4;
      end
      mPending = 0;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_rom_addr"}, rom_addr, mPc / 4);
    checkOutput({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, mValid});
    checkOutput({tag, "_fault"}, {31'd0, fetch_fault}, {31'd0, mFault});
    checkOutput({tag, "_count"}, fetch_count, mCount);
    if (mValid) begin
      checkOutput({tag, "_instr"}, if_id_instr, mInstr);
      checkOutput({tag, "_pc4"}, if_id_pc4, mPc4);
    end
  endtask

  // Drive one cycle of inputs, update the model on the edge and check just after it.
  task automatic applyStimulus(input string tag, input bit r, input bit s, input bit f,
                               input bit rv, input logic [31:0] rpc);
    @(negedge clk);
    rst = r; stall = s; flush = f; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk);
    modelEdge();
    #1;
    checkAll(tag);
  endtask

  initial begin
    logic [31:0] rpc;
    bit r, s, f, rv;
    checksTotal = 0;
    checksPassed = 0;
    for (int i = 0; i < ROMN; i++) rom[i] = $urandom;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    mPc = 32'd0; mInstr = 32'd0; mPc4 = 32'd0; mValid = 0;
    mFault = 0; mCount = 32'd0; mPending = 0; mPendingPc = 32'd0;

    // Reset state, then three sequential fetches.
    applyStimulus("reset", 1, 0, 0, 0, 32'd0);
    checkOutput("reset_addr_const", rom_addr, 32'd0);
    applyStimulus("seq0", 0, 0, 0, 0, 32'd0);
    applyStimulus("seq1", 0, 0, 0, 0, 32'd0);
    applyStimulus("seq2", 0, 0, 0, 0, 32'd0);
    checkOutput("seq_count_const", fetch_count, 32'd3);
    checkOutput("seq_pc4_const", if_id_pc4, 32'd12);
    checkOutput("seq_instr_c", if_id_instr, rom[2]);

    // Redirect applied from pc 0x10.
    applyStimulus("to10", 0, 0, 0, 0, 32'd0);
    applyStimulus("redir40", 0, 0, 0, 1, 32'h40);
    checkOutput("redir40_addr_const", rom_addr, 32'h10);
    checkOutput("redir40_slot_valid", {31'd0, if_id_valid}, {31'd0, DS});

    // A redirect that arrives during a stall is applied on the first unstalled edge.
    applyStimulus("stall1", 0, 1, 0, 0, 32'd0);
    applyStimulus("stall2", 0, 1, 0, 1, 32'h80);
    applyStimulus("stall3", 0, 1, 0, 0, 32'd0);
    checkOutput("stall_pc_frozen", rom_addr, 32'h10);
    applyStimulus("unstall", 0, 0, 0, 0, 32'd0);
    checkOutput("pending_applied", rom_addr, 32'h20);
    applyStimulus("after_pending", 0, 0, 0, 0, 32'd0);
    checkOutput("pending_cleared", rom_addr, 32'h21);

    // A flush during a stall drops valid and holds the PC.
    applyStimulus("stall_flush", 0, 1, 1, 0, 32'd0);
    checkOutput("stall_flush_valid", {31'd0, if_id_valid}, 32'd0);
    applyStimulus("post_flush", 0, 0, 0, 0, 32'd0);
    checkOutput("post_flush_valid", {31'd0, if_id_valid}, 32'd1);

    // Last ROM word, then an out-of-range fetch.
    applyStimulus("redir_ffc", 0, 0, 0, 1, 32'h0FFC);
    applyStimulus("word1023", 0, 0, 0, 0, 32'd0);
    checkOutput("word1023_valid", {31'd0, if_id_valid}, 32'd1);
    checkOutput("word1023_pc4", if_id_pc4, 32'h1000);
    applyStimulus("oob", 0, 0, 0, 0, 32'd0);
    checkOutput("oob_fault", {31'd0, fetch_fault}, 32'd1);
    checkOutput("oob_addr", rom_addr, 32'h400);
    applyStimulus("oob_redir", 0, 0, 0, 1, 32'h40);
    applyStimulus("oob_stall", 0, 1, 1, 1, 32'h80);
    checkOutput("oob_stuck", rom_addr, 32'h400);

    // A misaligned redirect faults, and reset recovers the stage.
    applyStimulus("reset2", 1, 0, 0, 0, 32'd0);
    applyStimulus("run2", 0, 0, 0, 0, 32'd0);
    applyStimulus("mis42", 0, 0, 0, 1, 32'h42);
    checkOutput("mis_fault", {31'd0, fetch_fault}, 32'd1);
    checkOutput("mis_pc_hold", rom_addr, 32'd1);
    applyStimulus("reset3", 1, 0, 0, 0, 32'd0);
    checkOutput("reset3_fault", {31'd0, fetch_fault}, 32'd0);
    checkOutput("reset3_count", fetch_count, 32'd0);
    checkOutput("reset3_addr", rom_addr, 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 49) == 0) || (mFault && $urandom_range(0, 3) == 0);
      s  = ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 5) == 0);
      rv = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 29) == 0) rpc = {20'd0, $urandom_range(0, 4095)};
      else if ($urandom_range(0, 7) == 0) rpc = {20'd0, $urandom_range(1016, 1023), 2'b00};
      else rpc = {20'd0, $urandom_range(0, 1023), 2'b00};
      applyStimulus("rand", r, s, f, rv, rpc);
    end

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
